// File: rtl/csa_128.sv
// ============================================================================
// csa_128 : registered 128-bit carry-select adder, {Cout, S} = A + B + Cin
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module csa_128_rca4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] w_c;

   assign w_c[0] = cin;

   generate
      for (genvar i = 0; i < 4; i++) begin : g_bit
         assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
         assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign cout = w_c[4];
endmodule

// 32-bit section: ripple low nibble, carry-select on the seven upper nibbles.
module csa_128_add32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);
   logic [8:0] w_c;

   assign w_c[0] = cin;

   csa_128_rca4 u_nib0 (
      .a    (a[3:0]),
      .b    (b[3:0]),
      .cin  (w_c[0]),
      .sum  (sum[3:0]),
      .cout (w_c[1])
   );

   generate
      for (genvar k = 1; k < 8; k++) begin : g_nib
         logic [3:0] w_s0;
         logic [3:0] w_s1;
         logic       w_c0;
         logic       w_c1;

         csa_128_rca4 u_lo (
            .a    (a[4*k +: 4]),
            .b    (b[4*k +: 4]),
            .cin  (1'b0),
            .sum  (w_s0),
            .cout (w_c0)
         );

         csa_128_rca4 u_hi (
            .a    (a[4*k +: 4]),
            .b    (b[4*k +: 4]),
            .cin  (1'b1),
            .sum  (w_s1),
            .cout (w_c1)
         );

         assign sum[4*k +: 4] = w_c[k] ? w_s1 : w_s0;
         assign w_c[k+1]      = w_c[k] ? w_c1 : w_c0;
      end
   endgenerate

   assign cout = w_c[8];
endmodule

module csa_128 (
   input  logic           clk,
   input  logic           rst,
   input  logic [127:0]   A,
   input  logic [127:0]   B,
   input  logic           Cin,
   output logic [127:0]   S,
   output logic           Cout
);
   logic [127:0] w_sum;
   logic [3:0]   w_sec_c;
   logic [127:0] r_sum;
   logic         r_cout;

   csa_128_add32 u_sec0 (
      .a    (A[31:0]),
      .b    (B[31:0]),
      .cin  (Cin),
      .sum  (w_sum[31:0]),
      .cout (w_sec_c[0])
   );

   // Upper sections precompute both carry-in cases; the chain is just 2:1 muxes.
   generate
      for (genvar k = 1; k < 4; k++) begin : g_sec
         logic [31:0] w_s0;
         logic [31:0] w_s1;
         logic        w_c0;
         logic        w_c1;

         csa_128_add32 u_add0 (
            .a    (A[32*k +: 32]),
            .b    (B[32*k +: 32]),
            .cin  (1'b0),
            .sum  (w_s0),
            .cout (w_c0)
         );

         csa_128_add32 u_add1 (
            .a    (A[32*k +: 32]),
            .b    (B[32*k +: 32]),
            .cin  (1'b1),
            .sum  (w_s1),
            .cout (w_c1)
         );

         assign w_sum[32*k +: 32] = w_sec_c[k-1] ? w_s1 : w_s0;
         assign w_sec_c[k]        = w_sec_c[k-1] ? w_c1 : w_c0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else begin
         r_sum  <= w_sum;
         r_cout <= w_sec_c[3];
      end
   end

   assign S    = r_sum;
   assign Cout = r_cout;
endmodule

`default_nettype wire

// File: tb/tb_csa_128.sv
// ============================================================================
// tb_csa_128 : randomized and directed bench for csa_128 with arithmetic model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_csa_128;
   logic           clk;
   logic           rst;
   logic [127:0]   A;
   logic [127:0]   B;
   logic           Cin;
   logic [127:0]   S;
   logic           Cout;

   int checks = 0;
   int passes = 0;

   logic [128:0] model_q;
   logic         model_valid = 1'b0;

   localparam logic [127:0] ONES = {128{1'b1}};

   csa_128 dut (
      .clk  (clk),
      .rst  (rst),
      .A    (A),
      .B    (B),
      .Cin  (Cin),
      .S    (S),
      .Cout (Cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: exact 129-bit sum of whatever was presented at the edge.
   always @(posedge clk) begin
      if (rst) model_q <= '0;
      else     model_q <= {1'b0, A} + {1'b0, B} + {128'd0, Cin};
      model_valid <= 1'b1;
   end

   always @(negedge clk) begin
      if (model_valid) check("model", {Cout, S}, model_q);
   end

   task automatic vec(input string name, input logic [127:0] a, input logic [127:0] b,
                      input logic c, input logic [128:0] exp);
      A   = a;
      B   = b;
      Cin = c;
      @(posedge clk);
      #1;
      check(name, {Cout, S}, exp);
   endtask

   initial begin
      logic [127:0] ra;
      logic [127:0] rb;

      rst = 1'b1;
      A   = ONES;
      B   = ONES;
      Cin = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset", {Cout, S}, 129'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset", {Cout, S}, {1'b1, ONES});

      vec("dir0", 128'd654251211, 128'd5151511, 1'b0, 129'd659402722);
      vec("dir1", 128'd5151511,   128'd321555,  1'b0, 129'd5473066);
      vec("dir2", 128'd321555,    128'd999925,  1'b0, 129'd1321480);
      vec("dir3", 128'd999925,    128'd75,      1'b0, 129'd1000000);
      vec("dir4", 128'd75,        128'd25,      1'b0, 129'd100);

      vec("bnd32", 128'hFFFF_FFFF, 128'd1, 1'b0, 129'h1_0000_0000);
      vec("bnd64", 128'hFFFF_FFFF_FFFF_FFFF, 128'd0, 1'b1, 129'h1_0000_0000_0000_0000);
      vec("bnd96", 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
          129'h1_0000_0000_0000_0000_0000_0000);

      vec("ovf0", ONES, 128'd1, 1'b0, {1'b1, 128'd0});
      vec("ovf1", ONES, ONES,   1'b1, {1'b1, ONES});

      for (int i = 0; i < 10000; i++) begin
         ra = {$urandom, $urandom, $urandom, $urandom};
         rb = {$urandom, $urandom, $urandom, $urandom};
         // Complementary operands force full-length carry propagation.
         if ($urandom_range(0, 7) == 0) rb = ~ra;
         A   = ra;
         B   = rb;
         Cin = 1'($urandom_range(0, 1));
         rst = (i == 5000);
         @(posedge clk);
         #1;
         if (i == 5000) check("mid_reset", {Cout, S}, 129'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      #1;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

`default_nettype wire
